// File: rtl/collision_arbiter.sv
// Per-frame player/object collision arbiter: one hit pulse per object per frame after
// MIN_OVERLAP overlapping pixels, previous-frame hit vector, saturating hit counter.
module collision_arbiter #(
  parameter int              N_OBJ       = 4,
  parameter int              MIN_OVERLAP = 1,
  parameter int              CNT_W       = 8,
  parameter logic [N_OBJ-2:0] PULSE_MASK = '1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [N_OBJ-1:0]   drawing_request,
  input  logic               clearCount,
  output logic               anyCollision,
  output logic [N_OBJ-2:0]   hitPulse,
  output logic [N_OBJ-2:0]   hitVector,
  output logic [CNT_W-1:0]   hitCount
);

  localparam int NO = N_OBJ - 1;
  localparam int OW = $clog2(MIN_OVERLAP + 1);
  localparam logic [OW-1:0]    OVL_SAT = OW'(MIN_OVERLAP);
  localparam logic [OW:0]      OVL_MIN = (OW+1)'(MIN_OVERLAP);
  localparam logic [OW:0]      OVL_ONE = (OW+1)'(1);
  localparam int SW = CNT_W + 5;
  localparam logic [SW-1:0]    CNT_MAX = {5'b0, {CNT_W{1'b1}}};

  logic [NO-1:0] overlap;
  logic [NO-1:0] qualify;
  logic [NO-1:0] fired_vec;

  assign overlap      = {NO{drawing_request[0]}} & drawing_request[N_OBJ-1:1];
  assign anyCollision = |overlap;

  // The startOfFrame pixel already belongs to the new frame, so it is judged
  // against cleared counter/flag state rather than the held values.
  for (genvar k = 0; k < NO; k++) begin : g_obj
    logic [OW-1:0] ovl_q;
    logic          fired_q;
    logic [OW-1:0] ovl_base;
    logic          fired_base;

    assign ovl_base   = startOfFrame ? '0 : ovl_q;
    assign fired_base = startOfFrame ? 1'b0 : fired_q;
    assign qualify[k] = overlap[k] & ~fired_base &
                        (({1'b0, ovl_base} + OVL_ONE) >= OVL_MIN);
    assign fired_vec[k] = fired_q;

    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        ovl_q   <= '0;
        fired_q <= 1'b0;
      end else begin
        if (overlap[k] && (ovl_base != OVL_SAT))
          ovl_q <= ovl_base + 1'b1;
        else
          ovl_q <= ovl_base;
        fired_q <= fired_base | qualify[k];
      end
    end
  end

  logic [SW-1:0] cnt_sum;

  always_comb begin
    cnt_sum = {5'b0, hitCount};
    for (int i = 0; i < NO; i++)
      cnt_sum = cnt_sum + SW'(hitPulse[i]);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hitPulse  <= '0;
      hitVector <= '0;
      hitCount  <= '0;
    end else begin
      hitPulse <= qualify & PULSE_MASK;
      if (startOfFrame)
        hitVector <= fired_vec;
      if (clearCount)
        hitCount <= '0;
      else if (cnt_sum > CNT_MAX)
        hitCount <= {CNT_W{1'b1}};
      else
        hitCount <= cnt_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_collision_arbiter.sv
// Directed bench for collision_arbiter: three instances (MIN_OVERLAP=1, MIN_OVERLAP=3,
// PULSE_MASK=3'b011) share one stimulus stream; each scenario checks one of them.
module tb_collision_arbiter;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic       clearCount;
  logic [3:0] dr;

  logic       any_a, any_b, any_c;
  logic [2:0] pulse_a, pulse_b, pulse_c;
  logic [2:0] vec_a, vec_b, vec_c;
  logic [7:0] cnt_a, cnt_b, cnt_c;

  int n_tests = 0;
  int n_fail  = 0;
  int npulse;

  always #5 clk = ~clk;

  collision_arbiter #(.N_OBJ(4), .MIN_OVERLAP(1), .CNT_W(8), .PULSE_MASK(3'b111)) u_a (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .drawing_request(dr),
    .clearCount(clearCount), .anyCollision(any_a), .hitPulse(pulse_a),
    .hitVector(vec_a), .hitCount(cnt_a));

  collision_arbiter #(.N_OBJ(4), .MIN_OVERLAP(3), .CNT_W(8), .PULSE_MASK(3'b111)) u_b (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .drawing_request(dr),
    .clearCount(clearCount), .anyCollision(any_b), .hitPulse(pulse_b),
    .hitVector(vec_b), .hitCount(cnt_b));

  collision_arbiter #(.N_OBJ(4), .MIN_OVERLAP(1), .CNT_W(8), .PULSE_MASK(3'b011)) u_c (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .drawing_request(dr),
    .clearCount(clearCount), .anyCollision(any_c), .hitPulse(pulse_c),
    .hitVector(vec_c), .hitCount(cnt_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_start();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; clearCount = 1'b0; dr = 4'b0000;
    #12;
    chk("rst_pulse", 32'(pulse_a), 0);
    chk("rst_vec",   32'(vec_a), 0);
    chk("rst_cnt",   32'(cnt_a), 0);
    dr = 4'b0101;
    #1 chk("rst_any_follows", 32'(any_a), 1);
    dr = 4'b0000;
    resetN = 1'b1;

    // long single overlap: one pulse only
    frame_start();
    dr = 4'b0101;
    #1 chk("s1_any", 32'(any_a), 1);
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pulse_a != 3'b000) npulse++;
      if (i == 0) chk("s1_first_pulse", 32'(pulse_a), 32'h2);
    end
    chk("s1_pulse_count", 32'(npulse), 1);
    chk("s1_hitcount", 32'(cnt_a), 1);
    dr = 4'b0000;
    frame_start();
    chk("s1_hitvector", 32'(vec_a), 32'h2);

    // MIN_OVERLAP=3: short overlaps split by a frame never qualify
    dr = 4'b0011;
    for (int i = 0; i < 2; i++) begin tick(); chk("s2_f1_nopulse", 32'(pulse_b), 0); end
    dr = 4'b0000;
    frame_start();
    dr = 4'b0011;
    for (int i = 0; i < 2; i++) begin tick(); chk("s2_f2_nopulse", 32'(pulse_b), 0); end
    dr = 4'b0000;
    frame_start();
    dr = 4'b0011;
    tick(); chk("s2_px1", 32'(pulse_b), 0);
    tick(); chk("s2_px2", 32'(pulse_b), 0);
    tick(); chk("s2_px3_pulse", 32'(pulse_b), 32'h1);
    dr = 4'b0000;
    tick(); chk("s2_pulse_width", 32'(pulse_b), 0);

    // masked object: collides and records, but never pulses or counts
    clearCount = 1'b1;
    tick();
    clearCount = 1'b0;
    chk("clr_cnt_b", 32'(cnt_b), 0);
    frame_start();
    chk("s2_hitvector_b", 32'(vec_b), 32'h1);
    dr = 4'b1001;
    #1 chk("mask_any_c", 32'(any_c), 1);
    chk("mask_any_b", 32'(any_b), 1);
    tick(); chk("mask_nopulse", 32'(pulse_c), 0);
    dr = 4'b0000;
    tick(); chk("mask_cnt", 32'(cnt_c), 0);
    frame_start();
    chk("mask_hitvector", 32'(vec_c), 32'h4);

    // overlap on the startOfFrame cycle with fired already set
    dr = 4'b0101;
    tick(); chk("sof_pre_pulse", 32'(pulse_a), 32'h2);
    dr = 4'b0000;
    tick(); chk("sof_pre_cnt", 32'(cnt_a), 2);
    dr = 4'b0101;
    frame_start();
    chk("sof_vec_old", 32'(vec_a), 32'h2);
    chk("sof_fresh_pulse", 32'(pulse_a), 32'h2);
    dr = 4'b0000;
    clearCount = 1'b1;
    tick(); chk("clr_vs_pulse", 32'(cnt_a), 0);
    clearCount = 1'b0;
    tick(); chk("clr_dropped", 32'(cnt_a), 0);

    // asynchronous reset mid-frame after a hit
    frame_start();
    dr = 4'b0101;
    tick();
    dr = 4'b0000;
    tick(); chk("rst_pre_cnt", 32'(cnt_a), 1);
    frame_start();
    chk("rst_pre_vec", 32'(vec_a), 32'h2);
    dr = 4'b0101;
    tick(); chk("rst_pre_pulse", 32'(pulse_a), 32'h2);
    resetN = 1'b0;
    #1;
    chk("arst_pulse", 32'(pulse_a), 0);
    chk("arst_vec",   32'(vec_a), 0);
    chk("arst_cnt",   32'(cnt_a), 0);
    chk("arst_any",   32'(any_a), 1);
    dr = 4'b0000;
    resetN = 1'b1;
    tick(); chk("post_rst_idle", 32'(pulse_a), 0);
    dr = 4'b0101;
    tick(); chk("post_rst_refire", 32'(pulse_a), 32'h2);
    tick(); chk("post_rst_once", 32'(pulse_a), 0);
    chk("post_rst_vec", 32'(vec_a), 0);
    dr = 4'b0000;

    // simultaneous hits and counter saturation
    clearCount = 1'b1;
    tick();
    clearCount = 1'b0;
    frame_start();
    for (int j = 0; j < 127; j++) begin
      dr = 4'b1011;
      tick();
      if (j == 0) chk("dual_pulse", 32'(pulse_a), 32'h5);
      dr = 4'b0000;
      tick();
      if (j == 0) chk("dual_cnt", 32'(cnt_a), 2);
      frame_start();
    end
    chk("cnt_254", 32'(cnt_a), 254);
    dr = 4'b1011;
    tick();
    dr = 4'b0000;
    tick(); chk("cnt_sat_255", 32'(cnt_a), 255);
    frame_start();
    dr = 4'b1011;
    tick();
    dr = 4'b0000;
    tick(); chk("cnt_hold_255", 32'(cnt_a), 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/collision_arbiter.md
# collision_arbiter

Parametrised per-frame collision arbiter for the VGA game datapath. It watches one player drawing request against N_OBJ-1 object drawing requests on every pixel clock. For each object it emits one registered hit pulse per frame, and only after a configurable number of overlapping pixels. It also latches the previous frame's hit vector and keeps a saturating hit counter for the score and lives logic. It sits between the object drawers/muxer and the game-state controllers.

## Interface
Parameters:
- N_OBJ, 4, total drawing-request channels; bit 0 is the player, bits N_OBJ-1..1 are objects; legal range 2..16
- MIN_OVERLAP, 1, overlapping pixels within one frame required before an object's hit is declared; ≥1
- CNT_W, 8, width of hitCount
- PULSE_MASK, all ones (N_OBJ-1 bits), bit k-1 enables hitPulse/hitCount for object k

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  pixel clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse at frame start
- drawing_request  in  N_OBJ  per-object drawing request for the current pixel; bit 0 = player
- clearCount  in  1  synchronous clear of hitCount
- anyCollision  out  1  combinational: player overlaps any object this pixel
- hitPulse  out  N_OBJ-1  registered one-cycle hit pulse; bit k-1 = object k
- hitVector  out  N_OBJ-1  registered; objects hit during the previous frame
- hitCount  out  CNT_W  registered saturating total of pulses issued

## Operation
- overlap[k] = drawing_request[0] & drawing_request[k], for k = 1..N_OBJ-1. anyCollision = OR of overlap[k] (unmasked, no register).
- Each object k has:
  - an overlap counter ovl[k], width clog2(MIN_OVERLAP+1), saturating at MIN_OVERLAP;
  - a fired[k] flag.
- Non-frame cycle:
  - if overlap[k], ovl[k] increments (saturating);
  - if overlap[k], ovl[k]+1 ≥ MIN_OVERLAP and !fired[k]: set fired[k]; hitPulse[k-1] is high next cycle if PULSE_MASK[k-1]=1.
- startOfFrame cycle:
  - hitVector <= fired (values held at the start of that cycle);
  - ovl and fired are cleared;
  - the pixel on this cycle belongs to the new frame, so overlap[k] is evaluated against the cleared state. With MIN_OVERLAP=1 a hit can fire on the startOfFrame cycle itself.
- Masked objects still count overlaps and still set fired/hitVector. They never pulse and never count.
- hitCount: each cycle add the number of hitPulse bits going high (popcount), saturating at 2^CNT_W-1.
  - clearCount has priority: hitCount <= 0 and increments on that cycle are dropped.
- At most one hitPulse per object per frame, whatever the overlap length or the number of separate overlap regions.
- A frame with no startOfFrame never rearms the flags; the fired state persists until the next startOfFrame.

## Timing
- Reset values: hitPulse=0, hitVector=0, hitCount=0, all ovl=0, all fired=0. anyCollision follows its inputs even during reset.
- Latency:
  - qualifying overlap pixel (cycle t) -> hitPulse high during cycle t+1, exactly one cycle wide;
  - pulse at t+1 -> hitCount updated at t+2;
  - startOfFrame at t -> hitVector valid at t+1, held for the whole frame.
- Simultaneous events:
  - several objects qualifying in one cycle pulse together;
  - hitCount adds all of them (saturating).
- Reset asserted mid-frame clears everything immediately. After release, nothing pulses until a new overlap qualifies. hitVector stays 0 until the first startOfFrame.
- No handshake; outputs are single-cycle or level. Consumers must sample hitPulse on every clk.

## Test plan
- N_OBJ=4, MIN_OVERLAP=1: player+obj2 overlap 20 consecutive pixels -> exactly one hitPulse=3'b010 one cycle after the first overlap; hitCount=1; next startOfFrame -> hitVector=3'b010.
- MIN_OVERLAP=3: obj1 overlaps 2 pixels, then startOfFrame, then 2 more -> no pulse in either frame. Then 3 pixels in one frame -> pulse on the cycle after the third pixel.
- obj1 and obj3 qualify on the same cycle -> hitPulse=3'b101; hitCount increments by 2. With hitCount=254 and CNT_W=8, the same event -> hitCount=255 (saturates).
- PULSE_MASK=3'b011: obj3 overlap -> anyCollision=1, no hitPulse, hitCount unchanged; next frame hitVector=3'b100.
- Overlap on the startOfFrame cycle with MIN_OVERLAP=1 and fired previously set -> hitVector captures the old fired, and a fresh pulse is issued next cycle. clearCount on the same cycle as a pulse -> hitCount=0.
- resetN pulled low mid-frame after a hit -> all outputs 0 asynchronously. After release, the same overlap re-fires once.
